// File: rtl/sar_search.sv
// Successive-approximation search engine: walks an N-bit value from MSB to LSB,
// asking an external comparator whether the target is >= each trial value.
module sar_search #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         cmp_valid,
   input  logic         cmp_ge,
   output logic [N-1:0] trial,
   output logic         trial_valid,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic [1:0]   state_dbg
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
   localparam logic [N-1:0]  ONE     = N'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  acc;
   logic [IW-1:0] idx;

   logic [N-1:0]  bit_mask;
   logic [N-1:0]  acc_upd;
   logic [N-1:0]  next_trial;

   // Handshake: trial is offered while trial_valid=1; a cycle with
   // trial_valid=1 and cmp_valid=1 consumes exactly one comparator result,
   // and trial is held stable for as long as cmp_valid stays low.
   always_comb begin
      bit_mask   = ONE << idx;
      acc_upd    = (acc & ~bit_mask) | (cmp_ge ? bit_mask : '0);
      next_trial = acc_upd | (bit_mask >> 1);
   end

   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         idx         <= IDX_TOP;
         trial       <= '0;
         trial_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state       <= PROBE;
                  acc         <= '0;
                  idx         <= IDX_TOP;
                  trial       <= ONE << (N - 1);
                  trial_valid <= 1'b1;
                  busy        <= 1'b1;
               end
            end

            PROBE: begin
               // abort wins over a comparator result arriving in the same cycle
               if (abort) begin
                  state       <= IDLE;
                  trial       <= '0;
                  trial_valid <= 1'b0;
                  busy        <= 1'b0;
               end else if (cmp_valid) begin
                  acc <= acc_upd;
                  if (idx != '0) begin
                     idx   <= idx - IW'(1);
                     trial <= next_trial;
                  end else begin
                     state       <= DONE;
                     trial       <= '0;
                     trial_valid <= 1'b0;
                     result      <= acc_upd;
                     done        <= 1'b1;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state       <= IDLE;
               trial       <= '0;
               trial_valid <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: table of searches with hand-computed trial
// sequences, plus abort and asynchronous-reset sequences.
module tb_sar_search;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic         cmp_valid;
   logic         cmp_ge;
   logic [N-1:0] trial;
   logic         trial_valid;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic [1:0]   state_dbg;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_q[$];

   typedef struct {
      logic [7:0]  target;
      logic [63:0] trials;
      logic [7:0]  exp_result;
      int          stall_probe;
      int          stall_len;
      int          start_probe;
      bit          start_in_done;
      int          exp_done;
   } vec_t;

   vec_t vecs[8];

   sar_search #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .cmp_valid   (cmp_valid),
      .cmp_ge      (cmp_ge),
      .trial       (trial),
      .trial_valid (trial_valid),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_invariants();
      check("trial_valid_is_probe", trial_valid, state_dbg == 2'd1);
      check("busy_not_idle", busy, state_dbg != 2'd0);
      check("done_is_done_state", done, state_dbg == 2'd2);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_trial"}, trial, 0);
      check({tag, "_trial_valid"}, trial_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   // driver + scoreboard for one search; entered and left at a negedge
   task automatic run_search(input vec_t v);
      int probe;
      int stall_left;
      int done_cyc;
      int cyc;
      exp_q.delete();
      for (int k = 0; k < N; k++) exp_q.push_back(v.trials[63 - 8*k -: 8]);
      start = 1'b1; cmp_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; probe = 0; stall_left = v.stall_len; done_cyc = -1;
      while (cyc < 40 && done_cyc < 0) begin
         check_invariants();
         start = 1'b0; cmp_valid = 1'b0; cmp_ge = 1'($urandom_range(0, 1));
         if (done) begin
            done_cyc = cyc;
            check("result_at_done", result, v.exp_result);
            if (v.start_in_done) start = 1'b1;
         end else if (trial_valid) begin
            if (probe + 1 == v.start_probe) start = 1'b1;
            if (exp_q.size() == 0) begin
               check("extra_probe", probe + 1, N);
            end else if (probe + 1 == v.stall_probe && stall_left > 0) begin
               stall_left--;
               check("trial_held_in_stall", trial, exp_q[0]);
            end else begin
               check("trial", trial, exp_q.pop_front());
               cmp_valid = 1'b1;
               cmp_ge    = (v.target >= trial);
               probe++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; cmp_valid = 1'b0;
      check("done_cycle", done_cyc, v.exp_done);
      check("probe_count", probe, N);
      check_invariants();
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      check("result_held", result, v.exp_result);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 64'h80C0A0B0_A8A4A6A5, 8'hA5, 0, 0, 0, 1'b0, 9};
      vecs[1] = '{8'h00, 64'h80402010_08040201, 8'h00, 0, 0, 0, 1'b0, 9};
      vecs[2] = '{8'hFF, 64'h80C0E0F0_F8FCFEFF, 8'hFF, 0, 0, 0, 1'b0, 9};
      vecs[3] = '{8'h3C, 64'h80402030_383C3E3D, 8'h3C, 3, 2, 0, 1'b0, 11};
      vecs[4] = '{8'h5A, 64'h80406050_585C5A5B, 8'h5A, 0, 0, 3, 1'b1, 9};
      vecs[5] = '{8'hC3, 64'h80C0E0D0_C8C4C2C3, 8'hC3, 1, 3, 6, 1'b0, 12};
      vecs[6] = '{8'h81, 64'h80C0A090_88848281, 8'h81, 8, 1, 0, 1'b0, 10};
      vecs[7] = '{8'h01, 64'h80402010_08040201, 8'h01, 0, 0, 0, 1'b0, 9};

      rst = 1'b1; start = 1'b0; abort = 1'b0; cmp_valid = 1'b0; cmp_ge = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // comparator, abort and cmp_ge activity in IDLE must be ignored
      cmp_valid = 1'b1; cmp_ge = 1'b1; abort = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_ignores_inputs_busy", busy, 0);
         check("idle_ignores_inputs_tv", trial_valid, 0);
      end
      cmp_valid = 1'b0; cmp_ge = 1'b0; abort = 1'b0;

      // back-to-back searches: each starts in the first IDLE cycle after done
      for (int i = 0; i < 7; i++) run_search(vecs[i]);

      // abort at probe 4 (priority over cmp_valid); result keeps 0x81
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cmp_valid = 1'b1; cmp_ge = (8'h3C >= trial);
         @(negedge clk);
      end
      check("abort_probe4_trial", trial, 8'h30);
      abort = 1'b1; cmp_valid = 1'b1; cmp_ge = 1'b1;
      @(negedge clk);
      abort = 1'b0; cmp_valid = 1'b0;
      check("abort_state_idle", state_dbg, 0);
      check("abort_busy", busy, 0);
      check("abort_trial_valid", trial_valid, 0);
      check("abort_result_held", result, 8'h81);
      repeat (3) begin
         check("abort_no_done", done, 0);
         @(negedge clk);
      end

      // asynchronous reset in the middle of a search
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cmp_valid = 1'b1; cmp_ge = (8'hA5 >= trial);
         @(negedge clk);
      end
      cmp_valid = 1'b0;
      check("pre_reset_busy", busy, 1);
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("post_reset_no_done", done, 0);
      run_search(vecs[7]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
